// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: size and FSM encodings, the registered request and
// big-endian lane helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_BYTE    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_RESP
  } state_e;

  // DataMemory only ever sees full-word commands; lane handling lives in the LSU.
  localparam logic [1:0] CMD_WORD = 2'b00;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] w_data;
  } req_t;

  // Big-endian: offset 0 is the most significant byte, so the shift grows as the offset shrinks.
  function automatic logic [4:0] lane_shift(size_e size, logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_shift = {~off, 3'b000};
      SIZE_HALF: lane_shift = {~off[1], 4'b0000};
      default:   lane_shift = 5'd0;
    endcase
  endfunction

  function automatic logic misaligned(size_e size, logic [1:0] off);
    case (size)
      SIZE_ILLEGAL: misaligned = 1'b1;
      SIZE_HALF:    misaligned = off[0];
      SIZE_WORD:    misaligned = (off != 2'b00);
      default:      misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and DataMemory signals of the LSU. The master side is the environment:
// it drives requests and also returns read data on behalf of the memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_w_data;
  logic        resp_valid;
  logic [31:0] resp_r_data;
  logic        resp_error;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_address;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;
  logic [1:0]  mem_read_command;
  logic [1:0]  mem_write_command;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_address, req_w_data, mem_r_data,
    input  req_ready, resp_valid, resp_r_data, resp_error, mem_r_en, mem_w_en,
           mem_address, mem_w_data, mem_read_command, mem_write_command
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_address, req_w_data, mem_r_data,
    output req_ready, resp_valid, resp_r_data, resp_error, mem_r_en, mem_w_en,
           mem_address, mem_w_data, mem_read_command, mem_write_command
  );
endinterface

// File: rtl/load_store_unit_mem_lane_align.sv
// Combinational lane steering: extracts/extends a sub-word load and merges a sub-word store
// into the word read from memory. Zero latency, no flow control.
module mem_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sgn,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] mask;

  always_comb begin
    shamt   = lane_shift(size, offset);
    lane    = rd_word >> shamt;
    ld_data = lane;
    mask    = '1;
    case (size)
      SIZE_BYTE: begin
        ld_data = {{24{sgn & lane[7]}}, lane[7:0]};
        mask    = 32'h0000_00FF << shamt;
      end
      SIZE_HALF: begin
        ld_data = {{16{sgn & lane[15]}}, lane[15:0]};
        mask    = 32'h0000_FFFF << shamt;
      end
      default: ;
    endcase
    st_word = (rd_word & ~mask) | ((new_data << shamt) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage LSU: one word-only DataMemory access sequence per request; latency 2+L load, 2 word
// store, 3+L sub-word store, 1 error. Req_ready only in IDLE, so the pipeline stalls while busy.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  state_e      state_q, state_d;
  req_t        req_q;
  logic [2:0]  wait_cnt_q;
  logic [31:0] resp_data_q;
  logic [31:0] wr_word_q;
  logic        resp_err_q;

  logic        accept;
  logic        req_err;
  logic        wait_done;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign accept    = (state_q == ST_IDLE) && bus.req_valid;
  assign req_err   = misaligned(size_e'(bus.req_size), bus.req_address[1:0]);
  assign wait_done = (wait_cnt_q == 3'(MEM_RD_LATENCY - 1));

  mem_lane_align u_align (
    .rd_word  (bus.mem_r_data),
    .new_data (req_q.w_data),
    .offset   (req_q.addr[1:0]),
    .size     (req_q.size),
    .sgn      (req_q.sgn),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_err)
            state_d = ST_RESP;
          else if (bus.req_write && (size_e'(bus.req_size) == SIZE_WORD))
            state_d = ST_WR;
          else
            state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: if (wait_done) state_d = req_q.write ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      wait_cnt_q  <= '0;
      resp_data_q <= '0;
      wr_word_q   <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        req_q.write  <= bus.req_write;
        req_q.size   <= size_e'(bus.req_size);
        req_q.sgn    <= bus.req_signed;
        req_q.addr   <= bus.req_address;
        req_q.w_data <= bus.req_w_data;
        resp_data_q  <= '0;
        resp_err_q   <= req_err;
        // A word store writes this directly; sub-word stores overwrite it with the merged word.
        wr_word_q    <= bus.req_w_data;
      end
      if (state_q == ST_RD) wait_cnt_q <= '0;
      if (state_q == ST_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 3'd1;
        if (wait_done) begin
          if (req_q.write) wr_word_q   <= st_word;
          else             resp_data_q <= ld_data;
        end
      end
    end
  end

  assign bus.req_ready         = (state_q == ST_IDLE);
  assign bus.resp_valid        = (state_q == ST_RESP);
  assign bus.resp_error        = (state_q == ST_RESP) && resp_err_q;
  assign bus.resp_r_data       = resp_data_q;
  assign bus.mem_r_en          = (state_q == ST_RD);
  assign bus.mem_w_en          = (state_q == ST_WR);
  assign bus.mem_address       = {req_q.addr[31:2], 2'b00};
  assign bus.mem_w_data        = wr_word_q;
  assign bus.mem_read_command  = CMD_WORD;
  assign bus.mem_write_command = CMD_WORD;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a one-cycle-latency word memory model and a scoreboard queue.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_RD_LATENCY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:15] = '{0: 32'hCADFEB89, 2: 32'h01234567, 7: 32'h11223344, default: 32'h0};

  always @(posedge clk) begin
    if (bus.mem_r_en) bus.mem_r_data <= mem[bus.mem_address[5:2]];
    if (bus.mem_w_en) mem[bus.mem_address[5:2]] <= bus.mem_w_data;
  end

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[20];

  function automatic vec_t mk(logic w, logic [1:0] sz, logic s, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] ed, logic ee, int lat, int rd, int wr);
    vec_t v;
    v.write = w; v.size = sz; v.sgn = s; v.addr = a; v.wdata = wd;
    v.exp_data = ed; v.exp_err = ee; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid   = 1'b1;
    bus.req_write   = v.write;
    bus.req_size    = v.size;
    bus.req_signed  = v.sgn;
    bus.req_address = v.addr;
    bus.req_w_data  = v.wdata;
  endtask

  // Scramble request fields after accept; the LSU must work from its registered copy.
  task automatic scramble();
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'($urandom);
    bus.req_size    = 2'($urandom);
    bus.req_signed  = 1'($urandom);
    bus.req_address = $urandom;
    bus.req_w_data  = $urandom;
  endtask

  task automatic do_req(input vec_t v, input string name);
    int   lat = 0, rd = 0, wr = 0, guard = 0;
    bit   got = 0, overlap = 0;
    vec_t e;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_ready"}, 32'(bus.req_ready), 32'd1);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1 scramble();
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.mem_r_en) rd++;
      if (bus.mem_w_en) wr++;
      if (bus.mem_r_en && bus.mem_w_en) overlap = 1;
      if (bus.resp_valid) got = 1;
    end
    chk({name, "_resp"}, 32'(got), 32'd1);
    if (got) begin
      e = exp_q.pop_front();
      chk({name, "_data"}, bus.resp_r_data, e.exp_data);
      chk({name, "_err"}, 32'(bus.resp_error), 32'(e.exp_err));
      chk({name, "_lat"}, 32'(lat), 32'(e.exp_lat));
      chk({name, "_rd_pulses"}, 32'(rd), 32'(e.exp_rd));
      chk({name, "_wr_pulses"}, 32'(wr), 32'(e.exp_wr));
      chk({name, "_overlap"}, 32'(overlap), 32'd0);
    end
    @(negedge clk);
    chk({name, "_pulse_end"}, 32'(bus.resp_valid), 32'd0);
    chk({name, "_ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad;
    vec_t v;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_address = '0; bus.req_w_data = '0;

    //                write size sgn addr         wdata          exp_data       err lat rd wr
    vecs[0]  = mk(1'b0, 2'd1, 1'b1, 32'd8,  32'h0,        32'h00000123, 1'b0, 3, 1, 0);
    vecs[1]  = mk(1'b0, 2'd1, 1'b1, 32'd10, 32'h0,        32'h00004567, 1'b0, 3, 1, 0);
    vecs[2]  = mk(1'b0, 2'd2, 1'b1, 32'd0,  32'h0,        32'hFFFFFFCA, 1'b0, 3, 1, 0);
    vecs[3]  = mk(1'b0, 2'd2, 1'b0, 32'd0,  32'h0,        32'h000000CA, 1'b0, 3, 1, 0);
    vecs[4]  = mk(1'b0, 2'd2, 1'b0, 32'd3,  32'h0,        32'h00000089, 1'b0, 3, 1, 0);
    vecs[5]  = mk(1'b0, 2'd1, 1'b1, 32'd0,  32'h0,        32'hFFFFCADF, 1'b0, 3, 1, 0);
    vecs[6]  = mk(1'b0, 2'd1, 1'b0, 32'd2,  32'h0,        32'h0000EB89, 1'b0, 3, 1, 0);
    vecs[7]  = mk(1'b0, 2'd2, 1'b1, 32'd2,  32'h0,        32'hFFFFFFEB, 1'b0, 3, 1, 0);
    vecs[8]  = mk(1'b1, 2'd0, 1'b0, 32'd24, 32'hBEADBEAD, 32'h00000000, 1'b0, 2, 0, 1);
    vecs[9]  = mk(1'b0, 2'd0, 1'b0, 32'd24, 32'h0,        32'hBEADBEAD, 1'b0, 3, 1, 0);
    vecs[10] = mk(1'b1, 2'd1, 1'b0, 32'd30, 32'h0000DDDD, 32'h00000000, 1'b0, 4, 1, 1);
    vecs[11] = mk(1'b0, 2'd0, 1'b0, 32'd28, 32'h0,        32'h1122DDDD, 1'b0, 3, 1, 0);
    vecs[12] = mk(1'b1, 2'd2, 1'b0, 32'd33, 32'h000000E0, 32'h00000000, 1'b0, 4, 1, 1);
    vecs[13] = mk(1'b0, 2'd0, 1'b0, 32'd32, 32'h0,        32'h00E00000, 1'b0, 3, 1, 0);
    vecs[14] = mk(1'b1, 2'd2, 1'b0, 32'd1,  32'h12345677, 32'h00000000, 1'b0, 4, 1, 1);
    vecs[15] = mk(1'b0, 2'd0, 1'b0, 32'd0,  32'h0,        32'hCA77EB89, 1'b0, 3, 1, 0);
    vecs[16] = mk(1'b0, 2'd2, 1'b1, 32'd1,  32'h0,        32'h00000077, 1'b0, 3, 1, 0);
    vecs[17] = mk(1'b0, 2'd0, 1'b0, 32'd6,  32'h0,        32'h00000000, 1'b1, 1, 0, 0);
    vecs[18] = mk(1'b0, 2'd1, 1'b1, 32'd9,  32'h0,        32'h00000000, 1'b1, 1, 0, 0);
    vecs[19] = mk(1'b1, 2'd3, 1'b0, 32'd0,  32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0, 0);

    #12;
    chk("rst_mem_r_en", 32'(bus.mem_r_en), 32'd0);
    chk("rst_mem_w_en", 32'(bus.mem_w_en), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
    chk("rst_mem_address", bus.mem_address, 32'd0);
    chk("rst_mem_w_data", bus.mem_w_data, 32'd0);
    chk("rst_resp_r_data", bus.resp_r_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("read_command", 32'(bus.mem_read_command), 32'd0);
    chk("write_command", 32'(bus.mem_write_command), 32'd0);

    for (int i = 0; i < 20; i++) do_req(vecs[i], $sformatf("v%0d", i));

    // Reset during WAIT of a sub-word store: nothing may reach memory or the response port.
    @(negedge clk);
    drive(mk(1'b1, 2'd2, 1'b0, 32'd1, 32'h000000AA, 32'h0, 1'b0, 0, 0, 0));
    @(posedge clk);
    #1 scramble();
    @(negedge clk);
    chk("abort_wait_rd_phase", 32'(bus.mem_r_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_wait_r_en", 32'(bus.mem_r_en), 32'd0);
    chk("abort_wait_w_en", 32'(bus.mem_w_en), 32'd0);
    chk("abort_wait_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.mem_w_en || bus.resp_valid) bad++;
    end
    chk("abort_wait_quiet", 32'(bad), 32'd0);
    chk("abort_wait_mem", mem[0], 32'hCA77EB89);

    // Reset while Mem_R_en is high: the enable must drop without waiting for a clock.
    @(negedge clk);
    drive(mk(1'b1, 2'd1, 1'b0, 32'd0, 32'h00005555, 32'h0, 1'b0, 0, 0, 0));
    @(posedge clk);
    #1 scramble();
    @(negedge clk);
    chk("abort_rd_phase", 32'(bus.mem_r_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rd_r_en", 32'(bus.mem_r_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.mem_w_en || bus.resp_valid) bad++;
    end
    chk("abort_rd_quiet", 32'(bad), 32'd0);

    v = mk(1'b0, 2'd0, 1'b0, 32'd0, 32'h0, 32'hCA77EB89, 1'b0, 3, 1, 0);
    do_req(v, "after_reset_lw");
    v = mk(1'b1, 2'd1, 1'b0, 32'd2, 32'hABCD1234, 32'h0, 1'b0, 4, 1, 1);
    do_req(v, "after_reset_sh");
    chk("after_reset_sh_mem", mem[0], 32'hCA771234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
